// File: rtl/id_stage.sv
// Instruction-decode stage of the 5-stage MIPS pipeline: IF/ID register, register file,
// ID-stage branch/jump resolution and load-use / branch-operand hazard detection.
module id_stage #(
    parameter logic [31:0] NOP = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instruction_if,
    input  logic [31:0] PC,
    input  logic        IF_flush,
    input  logic        WB_RegWrite,
    input  logic [4:0]  WB_WriteReg,
    input  logic [31:0] WB_WriteData,
    input  logic        EX_MemRead,
    input  logic        EX_RegWrite,
    input  logic [4:0]  EX_WriteReg,
    input  logic        MEM_RegWrite,
    input  logic        MEM_MemRead,
    input  logic [4:0]  MEM_WriteReg,
    input  logic [31:0] MEM_ALUResult,
    output logic        Branch,
    output logic        Jump,
    output logic [31:0] JumpAddr,
    output logic        IFWrite,
    output logic [31:0] RegData1_id,
    output logic [31:0] RegData2_id,
    output logic [31:0] Imm_id,
    output logic [4:0]  Rs_id,
    output logic [4:0]  Rt_id,
    output logic [4:0]  Rd_id,
    output logic [8:0]  Ctrl_id
);

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_SLTI  = 6'h0A,
        OP_ANDI  = 6'h0C,
        OP_ORI   = 6'h0D,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_e;

    typedef enum logic [5:0] {
        FN_ADD = 6'h20,
        FN_SUB = 6'h22,
        FN_AND = 6'h24,
        FN_OR  = 6'h25,
        FN_SLT = 6'h2A
    } funct_e;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_RTYPE = 3'b010,
        ALU_AND   = 3'b011,
        ALU_OR    = 3'b100,
        ALU_SLT   = 3'b101
    } aluop_e;

    typedef struct packed {
        logic   reg_dst;
        logic   alu_src;
        logic   mem_to_reg;
        logic   reg_write;
        logic   mem_read;
        logic   mem_write;
        aluop_e alu_op;
    } ctrl_t;

    logic [31:0] instr_id;
    logic [31:0] pc_id;
    logic [31:0] regs [32];

    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] rs_cmp;
    logic [31:0] rt_cmp;

    ctrl_t       ctrl;
    logic        uses_rs;
    logic        uses_rt;
    logic        is_beq;
    logic        is_bne;
    logic        is_j;
    logic        zext;
    logic        is_br;
    logic        load_use;
    logic        br_ex_hazard;
    logic        br_mem_hazard;
    logic        stall;

    logic [31:0] pc4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;

    // IF/ID pipeline register: flush wins over a stall hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_id <= NOP;
            pc_id    <= '0;
        end else if (IF_flush) begin
            instr_id <= NOP;
        end else if (IFWrite) begin
            instr_id <= Instruction_if;
            pc_id    <= PC;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (WB_RegWrite && WB_WriteReg != '0) begin
            regs[WB_WriteReg] <= WB_WriteData;
        end
    end

    assign rs = instr_id[25:21];
    assign rt = instr_id[20:16];

    // Register reads see a same-cycle writeback so WB never needs a separate bypass.
    always_comb begin
        rs_val = regs[rs];
        if (rs == '0) begin
            rs_val = '0;
        end else if (WB_RegWrite && WB_WriteReg == rs) begin
            rs_val = WB_WriteData;
        end
    end

    always_comb begin
        rt_val = regs[rt];
        if (rt == '0) begin
            rt_val = '0;
        end else if (WB_RegWrite && WB_WriteReg == rt) begin
            rt_val = WB_WriteData;
        end
    end

    assign rs_cmp = (MEM_RegWrite && !MEM_MemRead && MEM_WriteReg == rs && rs != '0)
                    ? MEM_ALUResult : rs_val;
    assign rt_cmp = (MEM_RegWrite && !MEM_MemRead && MEM_WriteReg == rt && rt != '0)
                    ? MEM_ALUResult : rt_val;

    always_comb begin
        ctrl    = '0;
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        is_beq  = 1'b0;
        is_bne  = 1'b0;
        is_j    = 1'b0;
        zext    = 1'b0;
        unique case (instr_id[31:26])
            OP_RTYPE: begin
                unique case (instr_id[5:0])
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: begin
                        ctrl.reg_dst   = 1'b1;
                        ctrl.reg_write = 1'b1;
                        ctrl.alu_op    = ALU_RTYPE;
                        uses_rs        = 1'b1;
                        uses_rt        = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_LW: begin
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.alu_op     = ALU_ADD;
                uses_rs         = 1'b1;
            end
            OP_SW: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                uses_rs        = 1'b1;
                uses_rt        = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                ctrl.alu_op = ALU_SUB;
                uses_rs     = 1'b1;
                uses_rt     = 1'b1;
                is_beq      = (instr_id[31:26] == OP_BEQ);
                is_bne      = (instr_id[31:26] == OP_BNE);
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                uses_rs        = 1'b1;
                unique case (instr_id[31:26])
                    OP_SLTI: ctrl.alu_op = ALU_SLT;
                    OP_ANDI: begin ctrl.alu_op = ALU_AND; zext = 1'b1; end
                    OP_ORI:  begin ctrl.alu_op = ALU_OR;  zext = 1'b1; end
                    default: ctrl.alu_op = ALU_ADD;
                endcase
            end
            OP_J: begin
                is_j = 1'b1;
            end
            default: ;
        endcase
    end

    assign is_br = is_beq || is_bne;

    assign load_use = EX_MemRead && EX_WriteReg != '0 &&
                      ((uses_rs && EX_WriteReg == rs) || (uses_rt && EX_WriteReg == rt));
    assign br_ex_hazard = is_br && EX_RegWrite && EX_WriteReg != '0 &&
                          (EX_WriteReg == rs || EX_WriteReg == rt);
    assign br_mem_hazard = is_br && MEM_MemRead && MEM_WriteReg != '0 &&
                           (MEM_WriteReg == rs || MEM_WriteReg == rt);
    assign stall = load_use || br_ex_hazard || br_mem_hazard;

    assign pc4           = pc_id + 32'd4;
    assign branch_target = pc4 + {Imm_id[29:0], 2'b00};
    assign jump_target   = {pc4[31:28], instr_id[25:0], 2'b00};

    assign IFWrite     = !stall;
    assign Ctrl_id     = stall ? '0 : ctrl;
    assign Branch      = !stall && ((is_beq && rs_cmp == rt_cmp) || (is_bne && rs_cmp != rt_cmp));
    assign Jump        = !stall && is_j;
    assign JumpAddr    = is_j ? jump_target : branch_target;
    assign RegData1_id = rs_val;
    assign RegData2_id = rt_val;
    assign Imm_id      = zext ? {16'h0000, instr_id[15:0]} : {{16{instr_id[15]}}, instr_id[15:0]};
    assign Rs_id       = rs;
    assign Rt_id       = rt;
    assign Rd_id       = instr_id[15:11];

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed pipeline scenarios followed by random traffic,
// checked against a mnemonic-level model of the decode stage.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instruction_if, PC;
    logic        IF_flush;
    logic        WB_RegWrite;
    logic [4:0]  WB_WriteReg;
    logic [31:0] WB_WriteData;
    logic        EX_MemRead, EX_RegWrite;
    logic [4:0]  EX_WriteReg;
    logic        MEM_RegWrite, MEM_MemRead;
    logic [4:0]  MEM_WriteReg;
    logic [31:0] MEM_ALUResult;
    logic        Branch, Jump, IFWrite;
    logic [31:0] JumpAddr, RegData1_id, RegData2_id, Imm_id;
    logic [4:0]  Rs_id, Rt_id, Rd_id;
    logic [8:0]  Ctrl_id;

    always #5 clk = ~clk;

    id_stage #(.NOP(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .Instruction_if(Instruction_if), .PC(PC), .IF_flush(IF_flush),
        .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg), .WB_WriteData(WB_WriteData),
        .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_WriteReg(EX_WriteReg),
        .MEM_RegWrite(MEM_RegWrite), .MEM_MemRead(MEM_MemRead), .MEM_WriteReg(MEM_WriteReg),
        .MEM_ALUResult(MEM_ALUResult),
        .Branch(Branch), .Jump(Jump), .JumpAddr(JumpAddr), .IFWrite(IFWrite),
        .RegData1_id(RegData1_id), .RegData2_id(RegData2_id), .Imm_id(Imm_id),
        .Rs_id(Rs_id), .Rt_id(Rt_id), .Rd_id(Rd_id), .Ctrl_id(Ctrl_id)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Architectural model: register file contents and the instruction/PC held in ID.
    logic [31:0] m_regs [32];
    logic [31:0] m_instr, m_pc;

    logic        e_branch, e_jump, e_ifwrite;
    logic [31:0] e_jaddr, e_rd1, e_rd2, e_imm;
    logic [4:0]  e_rs, e_rt, e_rd;
    logic [8:0]  e_ctrl;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic string mnem(input logic [31:0] w);
        case (w[31:26])
            6'h00: begin
                case (w[5:0])
                    6'h20: return "add";
                    6'h22: return "sub";
                    6'h24: return "and";
                    6'h25: return "or";
                    6'h2A: return "slt";
                    default: return "nop";
                endcase
            end
            6'h02: return "j";
            6'h04: return "beq";
            6'h05: return "bne";
            6'h08: return "addi";
            6'h0A: return "slti";
            6'h0C: return "andi";
            6'h0D: return "ori";
            6'h23: return "lw";
            6'h2B: return "sw";
            default: return "nop";
        endcase
    endfunction

    // {RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, ALUOp}
    function automatic logic [8:0] ctrl_of(input string m);
        case (m)
            "add", "sub", "and", "or", "slt": return 9'b100100_010;
            "lw":   return 9'b011110_000;
            "sw":   return 9'b010001_000;
            "beq", "bne": return 9'b000000_001;
            "addi": return 9'b010100_000;
            "andi": return 9'b010100_011;
            "ori":  return 9'b010100_100;
            "slti": return 9'b010100_101;
            default: return 9'b000000_000;
        endcase
    endfunction

    function automatic logic reads_rs(input string m);
        case (m)
            "j", "nop": return 1'b0;
            default:    return 1'b1;
        endcase
    endfunction

    function automatic logic reads_rt(input string m);
        case (m)
            "add", "sub", "and", "or", "slt", "sw", "beq", "bne": return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (WB_RegWrite && WB_WriteReg == r) return WB_WriteData;
        return m_regs[r];
    endfunction

    function automatic logic [31:0] m_operand(input logic [4:0] r);
        if (r != 5'd0 && MEM_RegWrite && !MEM_MemRead && MEM_WriteReg == r) return MEM_ALUResult;
        return m_read(r);
    endfunction

    task automatic predict();
        string       m;
        logic [4:0]  rs, rt;
        logic [31:0] a, b, pc4;
        logic        is_br, stall;
        m     = mnem(m_instr);
        rs    = m_instr[25:21];
        rt    = m_instr[20:16];
        e_rs  = rs;
        e_rt  = rt;
        e_rd  = m_instr[15:11];
        e_imm = (m == "andi" || m == "ori") ? {16'h0000, m_instr[15:0]}
                                           : {{16{m_instr[15]}}, m_instr[15:0]};
        e_rd1 = m_read(rs);
        e_rd2 = m_read(rt);
        is_br = (m == "beq" || m == "bne");
        stall = 1'b0;
        if (EX_MemRead && EX_WriteReg != 0 &&
            ((reads_rs(m) && EX_WriteReg == rs) || (reads_rt(m) && EX_WriteReg == rt)))
            stall = 1'b1;
        if (is_br && EX_RegWrite && EX_WriteReg != 0 && (EX_WriteReg == rs || EX_WriteReg == rt))
            stall = 1'b1;
        if (is_br && MEM_MemRead && MEM_WriteReg != 0 && (MEM_WriteReg == rs || MEM_WriteReg == rt))
            stall = 1'b1;
        a         = m_operand(rs);
        b         = m_operand(rt);
        e_ifwrite = !stall;
        e_ctrl    = stall ? 9'd0 : ctrl_of(m);
        e_branch  = !stall && ((m == "beq" && a == b) || (m == "bne" && a != b));
        e_jump    = !stall && (m == "j");
        pc4       = m_pc + 32'd4;
        e_jaddr   = (m == "j") ? {pc4[31:28], m_instr[25:0], 2'b00} : pc4 + (e_imm << 2);
    endtask

    // Called at posedge+1 with inputs already driven; returns at the following negedge.
    task automatic eval_and_check();
        predict();
        IF_flush = e_branch | e_jump;
        @(negedge clk);
        check("Branch",   32'(Branch),      32'(e_branch));
        check("Jump",     32'(Jump),        32'(e_jump));
        check("IFWrite",  32'(IFWrite),     32'(e_ifwrite));
        check("Ctrl_id",  32'(Ctrl_id),     32'(e_ctrl));
        check("Rs_id",    32'(Rs_id),       32'(e_rs));
        check("Rt_id",    32'(Rt_id),       32'(e_rt));
        check("Rd_id",    32'(Rd_id),       32'(e_rd));
        check("Imm_id",   Imm_id,           e_imm);
        check("RegData1", RegData1_id,      e_rd1);
        check("RegData2", RegData2_id,      e_rd2);
        if (e_branch || e_jump) check("JumpAddr", JumpAddr, e_jaddr);
    endtask

    task automatic advance();
        if (WB_RegWrite && WB_WriteReg != 0) m_regs[WB_WriteReg] = WB_WriteData;
        if (IF_flush) begin
            m_instr = 32'h0;
        end else if (e_ifwrite) begin
            m_instr = Instruction_if;
            m_pc    = PC;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        eval_and_check();
        advance();
    endtask

    task automatic clear_side();
        WB_RegWrite = 0; WB_WriteReg = 0; WB_WriteData = 0;
        EX_MemRead = 0; EX_RegWrite = 0; EX_WriteReg = 0;
        MEM_RegWrite = 0; MEM_MemRead = 0; MEM_WriteReg = 0; MEM_ALUResult = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_instr = 32'd0;
        m_pc    = 32'd0;
    endtask

    function automatic logic [31:0] rdata();
        if ($urandom_range(0, 1) == 1) return 32'($urandom_range(0, 3));
        return $urandom;
    endfunction

    task automatic rand_inputs();
        int          k;
        logic [4:0]  rs, rt, rd;
        logic [5:0]  iops [4];
        logic [5:0]  fns [5];
        iops = '{6'h08, 6'h0A, 6'h0C, 6'h0D};
        fns  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        k  = $urandom_range(0, 11);
        rs = 5'($urandom_range(0, 7));
        rt = 5'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 7));
        case (k)
            0, 1, 2, 3, 4: Instruction_if = enc_r(fns[k], rs, rt, rd);
            5:  Instruction_if = enc_i(6'h23, rs, rt, 16'($urandom));
            6:  Instruction_if = enc_i(6'h2B, rs, rt, 16'($urandom));
            7:  Instruction_if = enc_i(6'h04, rs, rt, 16'($urandom));
            8:  Instruction_if = enc_i(6'h05, rs, rt, 16'($urandom));
            9:  Instruction_if = enc_i(iops[$urandom_range(0, 3)], rs, rt, 16'($urandom));
            10: Instruction_if = {6'h02, 26'($urandom)};
            default: Instruction_if = $urandom;
        endcase
        PC            = $urandom & 32'hFFFF_FFFC;
        WB_RegWrite   = ($urandom_range(0, 1) == 1);
        WB_WriteReg   = 5'($urandom_range(0, 7));
        WB_WriteData  = rdata();
        EX_MemRead    = ($urandom_range(0, 3) == 0);
        EX_RegWrite   = ($urandom_range(0, 2) == 0);
        EX_WriteReg   = 5'($urandom_range(0, 7));
        MEM_RegWrite  = ($urandom_range(0, 1) == 1);
        MEM_MemRead   = ($urandom_range(0, 3) == 0);
        MEM_WriteReg  = 5'($urandom_range(0, 7));
        MEM_ALUResult = rdata();
    endtask

    initial begin
        reset = 1'b1;
        Instruction_if = 0; PC = 0; IF_flush = 0;
        clear_side();
        model_reset();
        e_ifwrite = 1'b1;
        @(posedge clk);
        #1;
        check("rst_IFWrite", 32'(IFWrite), 32'd1);
        check("rst_Branch",  32'(Branch),  32'd0);
        check("rst_Jump",    32'(Jump),    32'd0);
        check("rst_Ctrl",    32'(Ctrl_id), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // addi $1,$0,5 at PC=0; WB seeds $1=5 in the same cycle
        Instruction_if = enc_i(6'h08, 5'd0, 5'd1, 16'd5); PC = 32'h0;
        cycle();
        Instruction_if = 32'h0; PC = 32'h4;
        WB_RegWrite = 1; WB_WriteReg = 5'd1; WB_WriteData = 32'd5;
        eval_and_check();
        check("addi_Rt",      32'(Rt_id), 32'd1);
        check("addi_Imm",     Imm_id, 32'd5);
        check("addi_RegWr",   32'(Ctrl_id[5]), 32'd1);
        check("addi_ALUSrc",  32'(Ctrl_id[7]), 32'd1);
        check("addi_IFWrite", 32'(IFWrite), 32'd1);
        advance();
        clear_side();

        // load-use: lw $2 in EX, add $3,$2,$2 in ID
        Instruction_if = enc_r(6'h20, 5'd2, 5'd2, 5'd3); PC = 32'h8;
        cycle();
        Instruction_if = enc_i(6'h08, 5'd0, 5'd7, 16'd9); PC = 32'hC;
        EX_MemRead = 1; EX_RegWrite = 1; EX_WriteReg = 5'd2;
        eval_and_check();
        check("lu_IFWrite", 32'(IFWrite), 32'd0);
        check("lu_Ctrl",    32'(Ctrl_id), 32'd0);
        advance();
        clear_side();
        eval_and_check();
        check("lu_after_IFWrite", 32'(IFWrite), 32'd1);
        check("lu_after_Rd",      32'(Rd_id), 32'd3);
        check("lu_after_Ctrl",    32'(Ctrl_id), 32'h122);
        advance();

        // beq $1,$1,+3 at PC=0x10
        Instruction_if = enc_i(6'h04, 5'd1, 5'd1, 16'd3); PC = 32'h10;
        cycle();
        Instruction_if = enc_i(6'h08, 5'd0, 5'd7, 16'd9); PC = 32'h14;
        eval_and_check();
        check("beq_Branch", 32'(Branch), 32'd1);
        check("beq_Addr",   JumpAddr, 32'h20);
        advance();
        eval_and_check();
        check("beq_flush_Rt", 32'(Rt_id), 32'd0);
        advance();

        // j 0x40 at PC=0x8
        Instruction_if = {6'h02, 26'h10}; PC = 32'h8;
        cycle();
        Instruction_if = enc_i(6'h08, 5'd0, 5'd7, 16'd9); PC = 32'hC;
        eval_and_check();
        check("j_Jump", 32'(Jump), 32'd1);
        check("j_Addr", JumpAddr, 32'h40);
        advance();
        eval_and_check();
        check("j_flush_Rt", 32'(Rt_id), 32'd0);
        advance();

        // bne $4,$0 with MEM forwarding $4=7
        Instruction_if = enc_i(6'h05, 5'd4, 5'd0, 16'd2); PC = 32'h30;
        cycle();
        Instruction_if = enc_i(6'h08, 5'd0, 5'd7, 16'd9); PC = 32'h34;
        MEM_RegWrite = 1; MEM_WriteReg = 5'd4; MEM_ALUResult = 32'd7;
        eval_and_check();
        check("bne_fwd_Branch", 32'(Branch), 32'd1);
        advance();
        clear_side();
        Instruction_if = enc_i(6'h05, 5'd4, 5'd0, 16'd2); PC = 32'h40;
        cycle();
        // same branch with the producer still in EX
        Instruction_if = enc_i(6'h08, 5'd0, 5'd7, 16'd9); PC = 32'h44;
        EX_RegWrite = 1; EX_WriteReg = 5'd4;
        eval_and_check();
        check("bne_ex_IFWrite", 32'(IFWrite), 32'd0);
        check("bne_ex_Branch",  32'(Branch), 32'd0);
        advance();
        clear_side();
        MEM_RegWrite = 1; MEM_WriteReg = 5'd4; MEM_ALUResult = 32'd7;
        eval_and_check();
        check("bne_resolve_Branch", 32'(Branch), 32'd1);
        advance();
        clear_side();

        // WB write-through and $0 immutability
        Instruction_if = enc_r(6'h20, 5'd5, 5'd0, 5'd6);
        cycle();
        Instruction_if = enc_r(6'h20, 5'd0, 5'd0, 5'd6);
        WB_RegWrite = 1; WB_WriteReg = 5'd5; WB_WriteData = 32'hDEAD;
        eval_and_check();
        check("wt_RegData1", RegData1_id, 32'hDEAD);
        advance();
        WB_WriteReg = 5'd0; WB_WriteData = 32'hFFFF;
        eval_and_check();
        check("r0_wt_RegData1", RegData1_id, 32'd0);
        advance();
        clear_side();
        eval_and_check();
        check("r0_RegData1", RegData1_id, 32'd0);
        advance();

        // reset asserted in the middle of a load-use stall
        Instruction_if = enc_r(6'h20, 5'd2, 5'd2, 5'd3);
        cycle();
        EX_MemRead = 1; EX_WriteReg = 5'd2;
        eval_and_check();
        reset = 1'b1;
        #1;
        check("midrst_IFWrite", 32'(IFWrite), 32'd1);
        check("midrst_Ctrl",    32'(Ctrl_id), 32'd0);
        check("midrst_Rd",      32'(Rd_id), 32'd0);
        model_reset();
        clear_side();
        IF_flush = 0;
        Instruction_if = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        Instruction_if = enc_r(6'h20, 5'd5, 5'd1, 5'd6);
        cycle();
        eval_and_check();
        check("postrst_RegData1", RegData1_id, 32'd0);
        advance();

        for (int n = 0; n < 3000; n++) begin
            rand_inputs();
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
